// File: rtl/armleocpu_defines.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 op-codes and the sequencing state type.
package armleocpu_defines;

   localparam logic [2:0] FUNCT3_MUL    = 3'd0;
   localparam logic [2:0] FUNCT3_MULH   = 3'd1;
   localparam logic [2:0] FUNCT3_MULHSU = 3'd2;
   localparam logic [2:0] FUNCT3_MULHU  = 3'd3;
   localparam logic [2:0] FUNCT3_DIV    = 3'd4;
   localparam logic [2:0] FUNCT3_DIVU   = 3'd5;
   localparam logic [2:0] FUNCT3_REM    = 3'd6;
   localparam logic [2:0] FUNCT3_REMU   = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/armleocpu_muldiv_if.sv
// Request/response handshake bundle between the pipeline and the muldiv unit.
interface armleocpu_muldiv_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_operand0;
   logic [XLEN-1:0] in_operand1;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;

   // Pipeline side: issues requests, consumes results, may flush.
   modport master (
      output in_valid, in_funct3, in_operand0, in_operand1, kill, out_ready,
      input  in_ready, out_valid, out_result
   );

   // Execution unit side.
   modport slave (
      input  in_valid, in_funct3, in_operand0, in_operand1, kill, out_ready,
      output in_ready, out_valid, out_result
   );
endinterface

// File: rtl/armleocpu_div_step.sv
// One radix-2 restoring division step on unsigned magnitudes:
// shift the next dividend bit into the partial remainder, try to subtract
// the divisor, keep the difference only if it did not go negative.
module armleocpu_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] remainder,
   input  logic [XLEN-1:0] quotient,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] remainder_next,
   output logic [XLEN-1:0] quotient_next
);

   logic [XLEN:0] shifted;

   // Partial remainder is always below the divisor, so the shifted value
   // fits in XLEN+1 bits and a successful difference fits in XLEN bits.
   always_comb begin
      shifted = {remainder, quotient[XLEN-1]};
      if (shifted >= {1'b0, divisor}) begin
         remainder_next = shifted[XLEN-1:0] - divisor;
         quotient_next  = {quotient[XLEN-2:0], 1'b1};
      end else begin
         remainder_next = shifted[XLEN-1:0];
         quotient_next  = {quotient[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/armleocpu_muldiv.sv
// RISC-V M-extension multiply/divide unit. Multiplies finish in one
// execution cycle, divides iterate one quotient bit per cycle, and
// division corner cases (zero divisor, signed overflow) are resolved at
// acceptance. Results are held until consumed or flushed by kill.
module armleocpu_muldiv
   import armleocpu_defines::*;
#(
   parameter int XLEN = 32
) (
   input logic               clk,
   input logic               rst_n,
   armleocpu_muldiv_if.slave bus
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t    state_reg;
   logic [2:0]       funct3_reg;
   logic [XLEN-1:0]  operand0_reg;
   logic [XLEN-1:0]  operand1_reg;
   logic [XLEN-1:0]  remainder_reg;
   logic [XLEN-1:0]  quotient_reg;
   logic [XLEN-1:0]  divisor_reg;
   logic             negate_quotient_reg;
   logic             negate_remainder_reg;
   logic [CNT_W-1:0] counter_reg;
   logic [XLEN-1:0]  result_reg;

   logic             accept;
   logic             in_div_signed;
   logic             in_is_rem;
   logic             in_neg0;
   logic             in_neg1;
   logic [XLEN-1:0]  in_mag0;
   logic [XLEN-1:0]  in_mag1;
   logic             div_by_zero;
   logic             div_overflow;
   logic [XLEN-1:0]  special_result;

   logic             mul_signed0;
   logic             mul_signed1;
   logic [2*XLEN-1:0] mul_ext0;
   logic [2*XLEN-1:0] mul_ext1;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]  mul_result;

   logic [XLEN-1:0]  remainder_next;
   logic [XLEN-1:0]  quotient_next;
   logic [XLEN-1:0]  quotient_final;
   logic [XLEN-1:0]  remainder_final;
   logic [XLEN-1:0]  div_result;

   // Status outputs are plain decodes of the state register; the result
   // comes straight from a register, so nothing on the request side or
   // out_ready can reach out_result combinationally.
   assign bus.in_ready   = (state_reg == IDLE);
   assign bus.out_valid  = (state_reg == DONE);
   assign bus.out_result = result_reg;

   assign accept = bus.in_valid && (state_reg == IDLE) && !bus.kill;

   // Decode an incoming divide: signedness, magnitudes and corner cases.
   always_comb begin
      in_div_signed = (bus.in_funct3 == FUNCT3_DIV) || (bus.in_funct3 == FUNCT3_REM);
      in_is_rem     = (bus.in_funct3 == FUNCT3_REM) || (bus.in_funct3 == FUNCT3_REMU);
      in_neg0       = in_div_signed && bus.in_operand0[XLEN-1];
      in_neg1       = in_div_signed && bus.in_operand1[XLEN-1];
      in_mag0       = in_neg0 ? -bus.in_operand0 : bus.in_operand0;
      in_mag1       = in_neg1 ? -bus.in_operand1 : bus.in_operand1;
      div_by_zero   = (bus.in_operand1 == '0);
      div_overflow  = in_div_signed && (bus.in_operand0 == MOST_NEG) && (bus.in_operand1 == '1);
      if (div_by_zero) begin
         special_result = in_is_rem ? bus.in_operand0 : '1;
      end else begin
         special_result = in_is_rem ? '0 : bus.in_operand0;
      end
   end

   // Full-width product of the registered operands, extended per op type.
   always_comb begin
      mul_signed0 = (funct3_reg == FUNCT3_MULH) || (funct3_reg == FUNCT3_MULHSU);
      mul_signed1 = (funct3_reg == FUNCT3_MULH);
      mul_ext0    = {{XLEN{mul_signed0 && operand0_reg[XLEN-1]}}, operand0_reg};
      mul_ext1    = {{XLEN{mul_signed1 && operand1_reg[XLEN-1]}}, operand1_reg};
      product     = mul_ext0 * mul_ext1;
      case (funct3_reg)
         FUNCT3_MUL:                              mul_result = product[XLEN-1:0];
         FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: mul_result = product[2*XLEN-1:XLEN];
         default:                                 mul_result = product[2*XLEN-1:XLEN];
      endcase
   end

   armleocpu_div_step #(
      .XLEN (XLEN)
   ) u_div_step (
      .remainder      (remainder_reg),
      .quotient       (quotient_reg),
      .divisor        (divisor_reg),
      .remainder_next (remainder_next),
      .quotient_next  (quotient_next)
   );

   // Sign fix-up applied to the outcome of the final iteration.
   always_comb begin
      quotient_final  = negate_quotient_reg  ? -quotient_next  : quotient_next;
      remainder_final = negate_remainder_reg ? -remainder_next : remainder_next;
      case (funct3_reg)
         FUNCT3_DIV, FUNCT3_DIVU: div_result = quotient_final;
         default:                 div_result = remainder_final;
      endcase
   end

   // Sequencer: accept, multiply or iterate, then hold the result until
   // consumed. kill always wins and returns to IDLE without a result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg            <= IDLE;
         funct3_reg           <= '0;
         operand0_reg         <= '0;
         operand1_reg         <= '0;
         remainder_reg        <= '0;
         quotient_reg         <= '0;
         divisor_reg          <= '0;
         negate_quotient_reg  <= 1'b0;
         negate_remainder_reg <= 1'b0;
         counter_reg          <= '0;
         result_reg           <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  funct3_reg           <= bus.in_funct3;
                  operand0_reg         <= bus.in_operand0;
                  operand1_reg         <= bus.in_operand1;
                  remainder_reg        <= '0;
                  quotient_reg         <= in_mag0;
                  divisor_reg          <= in_mag1;
                  negate_quotient_reg  <= in_neg0 ^ in_neg1;
                  negate_remainder_reg <= in_neg0;
                  counter_reg          <= '0;
                  if (!bus.in_funct3[2]) begin
                     state_reg <= MUL;
                  end else if (div_by_zero || div_overflow) begin
                     result_reg <= special_result;
                     state_reg  <= DONE;
                  end else begin
                     state_reg <= DIV;
                  end
               end
            end
            MUL: begin
               if (bus.kill) begin
                  state_reg <= IDLE;
               end else begin
                  result_reg <= mul_result;
                  state_reg  <= DONE;
               end
            end
            DIV: begin
               if (bus.kill) begin
                  state_reg <= IDLE;
               end else begin
                  remainder_reg <= remainder_next;
                  quotient_reg  <= quotient_next;
                  counter_reg   <= counter_reg + CNT_W'(1);
                  if (counter_reg == LAST_STEP) begin
                     result_reg <= div_result;
                     state_reg  <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.kill || bus.out_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/armleocpu_muldiv.md
ARMLEOCPU_MULDIV -- requirements
Module: armleocpu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request; high iff state IDLE.
REQ-006 SHALL have port in_funct3  input  3  M-extension op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports in_operand0, in_operand1  input  XLEN  rs1, rs2 values.
REQ-008 SHALL have port kill  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have port out_valid  output  1  result available; high iff state DONE.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_result  output  XLEN  result; stable while out_valid is high.

Function
REQ-012 SHALL accept a request on a cycle with in_valid && in_ready && !kill, registering funct3 and both operands.
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-014 SHALL on accept go IDLE->MUL for funct3 0-3, IDLE->DONE for division special cases, and IDLE->DIV otherwise.
REQ-015 SHALL in MUL compute the registered 2*XLEN-bit product (signed*signed, signed*unsigned, unsigned*unsigned per op) and go to DONE next cycle; MUL returns the low half, MULH/MULHSU/MULHU the high half.
REQ-016 SHALL make the MUL-class latency exactly 2 cycles: accept at cycle N, out_valid at N+2.
REQ-017 SHALL perform division by a radix-2 restoring iteration: one quotient bit per cycle, XLEN cycles in DIV, then DONE; accept at N, out_valid at N+XLEN+1.
REQ-018 SHALL divide signed ops on magnitudes; the quotient is negated when the operand signs differ, and the remainder takes the sign of the dividend.
REQ-019 SHALL on divisor zero return all-ones for DIV/DIVU and operand0 for REM/REMU, with out_valid at N+1.
REQ-020 SHALL on signed overflow (operand0 = most-negative, operand1 = -1) return operand0 for DIV and 0 for REM, with out_valid at N+1.
REQ-021 SHALL hold DONE, out_valid and out_result unchanged until out_ready is high; DONE with out_ready -> IDLE next cycle.
REQ-022 SHALL NOT accept a new request in the same cycle a result is consumed, because in_ready is low in DONE.
REQ-023 SHALL on kill in MUL, DIV or DONE go to IDLE next cycle, produce no result, and drop out_valid next cycle; kill in IDLE blocks acceptance that cycle only.
REQ-024 SHALL give kill priority over out_ready when both are high in DONE; the result is discarded.
REQ-025 SHALL keep the iteration counter $clog2(XLEN)+1 bits wide, so it never wraps within one operation.

Reset
REQ-026 SHALL on rst_n low force state IDLE, in_ready 1, out_valid 0, out_result 0, counter 0, regardless of clk.
REQ-027 SHALL abandon any operation in progress when reset asserts mid-operation, and produce no result after release.
REQ-028 SHALL accept a request on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the funct3 op-code constants and the state enum typedef in the shared armleocpu_defines package.
REQ-030 SHALL isolate the unsigned restoring step (remainder/quotient shift, subtract, restore) in sub-module armleocpu_div_step, parametrised by XLEN.
REQ-031 SHALL contain no combinational path from in_* or out_ready to out_result.

Verification (XLEN=32)
REQ-032 SHALL cover: MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB at N+2; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, each at N+33.
REQ-034 SHALL cover: DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5 / 0 -> 5 at N+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0 at N+1.
REQ-035 SHALL cover: out_ready held low 10 cycles in DONE -> out_valid and out_result stable throughout, in_ready low throughout.
REQ-036 SHALL cover: kill at N+5 of a DIV -> out_valid never rises, in_ready high at N+6, and the next MUL returns a correct result.
REQ-037 SHALL cover: rst_n pulsed low at N+10 of a DIV -> outputs at reset values immediately, no out_valid afterwards.
